// File: rtl/cram_stream_master_pkg.sv
// Shared definitions for the RAM stream master: access-mode codes and FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cram_stream_master_pkg;

    // Access widths understood by the RAM Ld/St port.
    localparam logic [1:0] MODE_BYTE  = 2'd0;
    localparam logic [1:0] MODE_SHORT = 2'd1;
    localparam logic [1:0] MODE_INT   = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_DRAIN,
        ST_DONE
    } cram_master_state_t;

endpackage

// File: rtl/cram_stream_master_stream_skid_fifo.sv
// Two-entry synchronous FIFO with occupancy count; push and pop may coincide.
// Latency: pushed data is visible on pop_data the cycle after the push.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
//
// Ports: clock/reset (sync, active-high); push/push_data write side;
//        pop/pop_data read side (pop_data valid while !empty); count/empty/full status.
module stream_skid_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    assign do_pop   = pop && !empty;
    // When full, the slot being popped this cycle is the one the write lands in.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cram_stream_master.sv
// Sequences one block-transfer command into per-element RAM load/store requests.
// Latency: first request the cycle after command accept; load data appears 2 cycles after its request.
// Backpressure: loads stall when the 2-entry return buffer plus in-flight response would overflow;
//               stores issue only while I_Wr_Valid is high.
//
// Ports: I_Cmd_* command handshake (O_Cmd_Ready high in IDLE); O_Ld_*/I_Ld_* and O_St_* RAM port;
//        I_Wr_*/O_Wr_Ready store stream in; O_Rd_*/I_Rd_Ready load stream out;
//        O_Busy, O_Done (end pulse), O_Err (reject pulse).
module cram_stream_master
    import cram_stream_master_pkg::*;
#(
    parameter int WIDTH_DATA   = 32,
    parameter int WIDTH_ADDR   = 10,
    parameter int WIDTH_LENGTH = 10,
    parameter int BUF_DEPTH    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Cmd_Valid,
    output logic                    O_Cmd_Ready,
    input  logic                    I_Cmd_Store,
    input  logic [1:0]              I_Cmd_Mode,
    input  logic                    I_Cmd_Signed,
    input  logic [WIDTH_ADDR-1:0]   I_Cmd_Base,
    input  logic [WIDTH_LENGTH-1:0] I_Cmd_Length,
    input  logic [WIDTH_ADDR-1:0]   I_Cmd_Stride,
    output logic                    O_Ld_Req,
    output logic [1:0]              O_Ld_Mode,
    output logic [WIDTH_ADDR-1:0]   O_Ld_Address,
    input  logic                    I_Ld_Valid,
    input  logic [WIDTH_DATA-1:0]   I_Ld_Data,
    output logic                    O_St_Req,
    output logic [1:0]              O_St_Mode,
    output logic [WIDTH_ADDR-1:0]   O_St_Address,
    output logic [WIDTH_DATA-1:0]   O_St_Data,
    input  logic                    I_Wr_Valid,
    output logic                    O_Wr_Ready,
    input  logic [WIDTH_DATA-1:0]   I_Wr_Data,
    output logic                    O_Rd_Valid,
    input  logic                    I_Rd_Ready,
    output logic [WIDTH_DATA-1:0]   O_Rd_Data,
    output logic                    O_Busy,
    output logic                    O_Done,
    output logic                    O_Err
);

    cram_master_state_t          state;
    logic [WIDTH_ADDR-1:0]       addr_q;
    logic [WIDTH_ADDR-1:0]       stride_q;
    logic [WIDTH_LENGTH-1:0]     remain_q;
    logic [1:0]                  mode_q;
    logic                        signed_q;
    logic                        inflight_q;
    logic                        done_q;
    logic                        err_q;

    logic [1:0]                  buf_count;
    logic                        buf_empty;
    logic                        buf_full;
    logic [WIDTH_DATA-1:0]       buf_dout;
    logic [WIDTH_DATA-1:0]       ext_data;
    logic [2:0]                  occupancy;
    logic                        room;
    logic                        ld_req;
    logic                        st_req;
    logic                        issue;
    logic                        push;
    logic                        pop;
    logic                        last_elem;
    logic                        drain_ok;
    logic                        cmd_bad;

    assign pop       = !buf_empty && I_Rd_Ready;
    // Only a response in the slot right after our own request is accepted.
    assign push      = I_Ld_Valid && inflight_q;
    // Buffered + in-flight entries, with a same-cycle pop freeing a slot.
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight_q};
    assign room      = occupancy < (3'(BUF_DEPTH) + {2'b00, pop});
    assign last_elem = (remain_q == WIDTH_LENGTH'(1));

    assign ld_req = !reset && (state == ST_LOAD) && (remain_q != '0) && room;
    assign st_req = !reset && (state == ST_STORE) && I_Wr_Valid;
    assign issue  = ld_req || st_req;

    // Last entry may leave this cycle; nothing can arrive once inflight is clear.
    assign drain_ok = !inflight_q && ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop));

    always_comb begin
        cmd_bad = 1'b0;
        case (I_Cmd_Mode)
            MODE_SHORT: cmd_bad = I_Cmd_Base[0] | I_Cmd_Stride[0];
            MODE_INT:   cmd_bad = (|I_Cmd_Base[1:0]) | (|I_Cmd_Stride[1:0]);
            MODE_RSVD:  cmd_bad = 1'b1;
            default:    cmd_bad = 1'b0;
        endcase
    end

    // The RAM returns narrow data zero-filled; extend it on the way into the buffer.
    always_comb begin
        ext_data = I_Ld_Data;
        case (mode_q)
            MODE_BYTE:  ext_data = {{(WIDTH_DATA-8){signed_q & I_Ld_Data[7]}}, I_Ld_Data[7:0]};
            MODE_SHORT: ext_data = {{(WIDTH_DATA-16){signed_q & I_Ld_Data[15]}}, I_Ld_Data[15:0]};
            default:    ext_data = I_Ld_Data;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            stride_q   <= '0;
            remain_q   <= '0;
            mode_q     <= 2'd0;
            signed_q   <= 1'b0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= ld_req;
            if (issue) begin
                addr_q   <= addr_q + stride_q;
                remain_q <= remain_q - WIDTH_LENGTH'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (I_Cmd_Valid) begin
                        addr_q   <= I_Cmd_Base;
                        stride_q <= I_Cmd_Stride;
                        remain_q <= I_Cmd_Length;
                        mode_q   <= I_Cmd_Mode;
                        signed_q <= I_Cmd_Signed;
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                        end else if (I_Cmd_Length == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= I_Cmd_Store ? ST_STORE : ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (ld_req && last_elem) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_STORE: begin
                    if (st_req && last_elem) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_ok) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    stream_skid_fifo #(
        .WIDTH (WIDTH_DATA)
    ) u_ret_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (ext_data),
        .pop       (pop),
        .pop_data  (buf_dout),
        .count     (buf_count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    assign O_Cmd_Ready  = (state == ST_IDLE);
    assign O_Busy       = (state != ST_IDLE);
    assign O_Done       = done_q;
    assign O_Err        = err_q;
    assign O_Ld_Req     = ld_req;
    assign O_Ld_Mode    = mode_q;
    assign O_Ld_Address = addr_q;
    assign O_St_Req     = st_req;
    assign O_St_Mode    = mode_q;
    assign O_St_Address = addr_q;
    assign O_St_Data    = st_req ? I_Wr_Data : '0;
    assign O_Wr_Ready   = (state == ST_STORE);
    assign O_Rd_Valid   = !buf_empty;
    // buf_full is implied by occupancy accounting; exposed by the FIFO for other users.
    assign O_Rd_Data    = (buf_full || !buf_empty) ? buf_dout : '0;

endmodule

// File: tb/tb_cram_stream_master.sv
module tb_cram_stream_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        I_Cmd_Valid, O_Cmd_Ready, I_Cmd_Store, I_Cmd_Signed;
    logic [1:0]  I_Cmd_Mode;
    logic [9:0]  I_Cmd_Base, I_Cmd_Length, I_Cmd_Stride;
    logic        O_Ld_Req, O_St_Req;
    logic [1:0]  O_Ld_Mode, O_St_Mode;
    logic [9:0]  O_Ld_Address, O_St_Address;
    logic [31:0] O_St_Data;
    logic        I_Ld_Valid;
    logic [31:0] I_Ld_Data;
    logic        I_Wr_Valid, O_Wr_Ready;
    logic [31:0] I_Wr_Data;
    logic        O_Rd_Valid, I_Rd_Ready;
    logic [31:0] O_Rd_Data;
    logic        O_Busy, O_Done, O_Err;

    cram_stream_master dut (
        .clock(clock), .reset(reset),
        .I_Cmd_Valid(I_Cmd_Valid), .O_Cmd_Ready(O_Cmd_Ready), .I_Cmd_Store(I_Cmd_Store),
        .I_Cmd_Mode(I_Cmd_Mode), .I_Cmd_Signed(I_Cmd_Signed), .I_Cmd_Base(I_Cmd_Base),
        .I_Cmd_Length(I_Cmd_Length), .I_Cmd_Stride(I_Cmd_Stride),
        .O_Ld_Req(O_Ld_Req), .O_Ld_Mode(O_Ld_Mode), .O_Ld_Address(O_Ld_Address),
        .I_Ld_Valid(I_Ld_Valid), .I_Ld_Data(I_Ld_Data),
        .O_St_Req(O_St_Req), .O_St_Mode(O_St_Mode), .O_St_Address(O_St_Address), .O_St_Data(O_St_Data),
        .I_Wr_Valid(I_Wr_Valid), .O_Wr_Ready(O_Wr_Ready), .I_Wr_Data(I_Wr_Data),
        .O_Rd_Valid(O_Rd_Valid), .I_Rd_Ready(I_Rd_Ready), .O_Rd_Data(O_Rd_Data),
        .O_Busy(O_Busy), .O_Done(O_Done), .O_Err(O_Err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-addressed RAM image used by the load responder.
    logic [7:0] mem [0:1023];

    function automatic logic [31:0] mem_rd(input logic [9:0] a, input logic [1:0] mode);
        logic [31:0] w;
        w = {mem[(int'(a)+3) & 1023], mem[(int'(a)+2) & 1023], mem[(int'(a)+1) & 1023], mem[a]};
        case (mode)
            2'd0:    return {24'h0, w[7:0]};
            2'd1:    return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic set_word(input int a, input logic [31:0] w);
        mem[a] = w[7:0]; mem[a+1] = w[15:8]; mem[a+2] = w[23:16]; mem[a+3] = w[31:24];
    endtask

    // Monitor logs (sampled on the falling edge).
    logic [9:0]  ld_addr_q [$];
    int          ld_cyc_q  [$];
    logic [31:0] rd_q      [$];
    logic [9:0]  st_addr_q [$];
    logic [31:0] st_data_q [$];
    logic [1:0]  st_mode_last;
    int st_last_cyc, first_rd, rd_valid_cnt, done_cnt, done_cyc, err_cnt, err_cyc, nrdy_cnt, max_out;
    logic        pend_req = 1'b0;
    logic [9:0]  pend_addr;
    logic [1:0]  pend_mode;
    logic        inject = 1'b0;

    always @(negedge clock) begin
        if (O_Ld_Req) begin ld_addr_q.push_back(O_Ld_Address); ld_cyc_q.push_back(cyc); end
        pend_req = O_Ld_Req; pend_addr = O_Ld_Address; pend_mode = O_Ld_Mode;
        if (O_St_Req) begin
            st_addr_q.push_back(O_St_Address); st_data_q.push_back(O_St_Data);
            st_mode_last = O_St_Mode; st_last_cyc = cyc;
        end
        if (O_Rd_Valid) begin
            rd_valid_cnt++;
            if (first_rd < 0) first_rd = cyc;
            if (I_Rd_Ready) rd_q.push_back(O_Rd_Data);
        end
        if (O_Done) begin done_cnt++; done_cyc = cyc; end
        if (O_Err) begin err_cnt++; err_cyc = cyc; end
        if (!O_Cmd_Ready) nrdy_cnt++;
        if (ld_addr_q.size() - rd_q.size() > max_out) max_out = ld_addr_q.size() - rd_q.size();
    end

    // RAM model: answer each load request exactly one cycle later.
    initial begin
        I_Ld_Valid = 1'b0; I_Ld_Data = '0;
        forever begin
            @(posedge clock); #2;
            I_Ld_Valid = pend_req | inject;
            I_Ld_Data  = pend_req ? mem_rd(pend_addr, pend_mode) : 32'hDEADBEEF;
        end
    end

    task automatic clear_logs();
        ld_addr_q.delete(); ld_cyc_q.delete(); rd_q.delete(); st_addr_q.delete(); st_data_q.delete();
        st_last_cyc = -1; first_rd = -1; rd_valid_cnt = 0; done_cnt = 0; done_cyc = -1;
        err_cnt = 0; err_cyc = -1; nrdy_cnt = 0; max_out = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic send_cmd(input logic st, input logic [1:0] mode, input logic sgn,
                            input logic [9:0] base, input logic [9:0] len, input logic [9:0] stride,
                            output int t);
        @(posedge clock); #1;
        I_Cmd_Valid = 1'b1; I_Cmd_Store = st; I_Cmd_Mode = mode; I_Cmd_Signed = sgn;
        I_Cmd_Base = base; I_Cmd_Length = len; I_Cmd_Stride = stride;
        t = cyc;
        @(posedge clock); #1;
        I_Cmd_Valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin step(1); n++; end
        step(1);
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    int t;
    logic [31:0] exp_w [8];

    initial begin
        reset = 1'b1; I_Cmd_Valid = 0; I_Cmd_Store = 0; I_Cmd_Mode = 0; I_Cmd_Signed = 0;
        I_Cmd_Base = 0; I_Cmd_Length = 0; I_Cmd_Stride = 0;
        I_Wr_Valid = 0; I_Wr_Data = 0; I_Rd_Ready = 1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        set_word(12'h010, 32'h11223344); set_word(12'h014, 32'hA5A5_0001);
        set_word(12'h018, 32'hCAFE_F00D); set_word(12'h01C, 32'h8000_0007);
        mem[5] = 8'h80; mem[12'h020] = 8'h01; mem[12'h021] = 8'h80;
        exp_w = '{32'h0BAD_0000, 32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003,
                  32'h0BAD_0004, 32'h0BAD_0005, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) set_word(12'h040 + 4*i, exp_w[i]);
        clear_logs();
        step(3);
        reset = 1'b0;
        @(negedge clock);
        check("rst_flags", {O_Cmd_Ready, O_Busy, O_Ld_Req, O_St_Req, O_Rd_Valid, O_Wr_Ready, O_Done, O_Err}, 8'b1000_0000);
        check("rst_addr", {O_Ld_Address, O_St_Address, O_Ld_Mode, O_St_Mode}, 32'h0);

        // Word load, base 0x010 stride 4 length 4.
        clear_logs();
        send_cmd(0, 2'd2, 0, 10'h010, 10'd4, 10'd4, t);
        wait_done("wload", 30);
        check("wload_nreq", ld_addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wload_addr%0d", i), ld_addr_q[i], 32'h010 + 4*i);
            check($sformatf("wload_cyc%0d", i), ld_cyc_q[i], t + 1 + i);
        end
        check("wload_nrd", rd_q.size(), 4);
        check("wload_d0", rd_q[0], 32'h11223344);
        check("wload_d1", rd_q[1], 32'hA5A50001);
        check("wload_d2", rd_q[2], 32'hCAFEF00D);
        check("wload_d3", rd_q[3], 32'h80000007);
        check("wload_first_rd", first_rd, t + 3);
        check("wload_done_cyc", done_cyc, t + 7);

        // Byte loads, signed and unsigned; signed half load.
        clear_logs();
        send_cmd(0, 2'd0, 1, 10'h005, 10'd1, 10'd1, t);
        wait_done("sbyte", 20);
        check("sbyte_data", rd_q[0], 32'hFFFFFF80);
        clear_logs();
        send_cmd(0, 2'd0, 0, 10'h005, 10'd1, 10'd1, t);
        wait_done("ubyte", 20);
        check("ubyte_data", rd_q[0], 32'h00000080);
        clear_logs();
        send_cmd(0, 2'd1, 1, 10'h020, 10'd1, 10'd2, t);
        wait_done("shalf", 20);
        check("shalf_data", rd_q[0], 32'hFFFF8001);

        // Half store with address wrap.
        clear_logs();
        I_Wr_Valid = 1'b1; I_Wr_Data = 32'h0000BEEF;
        send_cmd(1, 2'd1, 0, 10'h3FE, 10'd2, 10'd2, t);
        for (int n = 0; n < 20 && st_addr_q.size() < 2; n++) begin
            if (st_addr_q.size() == 1) I_Wr_Data = 32'h00001234;
            step(1);
        end
        I_Wr_Valid = 1'b0;
        wait_done("hstore", 20);
        check("hstore_n", st_addr_q.size(), 2);
        check("hstore_a0", st_addr_q[0], 32'h3FE);
        check("hstore_a1", st_addr_q[1], 32'h000);
        check("hstore_d0", st_data_q[0], 32'h0000BEEF);
        check("hstore_d1", st_data_q[1], 32'h00001234);
        check("hstore_mode", st_mode_last, 2'd1);
        check("hstore_done_cyc", done_cyc, st_last_cyc + 1);
        check("hstore_no_ld", ld_addr_q.size(), 0);

        // Backpressure: output stalled for 5 cycles mid-stream.
        clear_logs();
        send_cmd(0, 2'd2, 0, 10'h040, 10'd6, 10'd4, t);
        step(2);
        I_Rd_Ready = 1'b0;
        step(5);
        I_Rd_Ready = 1'b1;
        wait_done("bp", 40);
        check("bp_nreq", ld_addr_q.size(), 6);
        check("bp_max_out", max_out, 2);
        check("bp_nrd", rd_q.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("bp_d%0d", i), rd_q[i], exp_w[i]);

        // Rejected commands.
        clear_logs();
        send_cmd(0, 2'd3, 0, 10'h000, 10'd2, 10'd4, t);
        step(2);
        send_cmd(0, 2'd2, 0, 10'h002, 10'd2, 10'd4, t);
        step(3);
        check("rej_err_cnt", err_cnt, 2);
        check("rej_err_cyc", err_cyc, t + 1);
        check("rej_no_req", ld_addr_q.size() + st_addr_q.size(), 0);
        check("rej_ready_low", nrdy_cnt, 0);
        check("rej_no_done", done_cnt, 0);
        clear_logs();
        send_cmd(1, 2'd0, 0, 10'h000, 10'd0, 10'd1, t);
        step(3);
        check("len0_done_cnt", done_cnt, 1);
        check("len0_done_cyc", done_cyc, t + 1);
        check("len0_no_req_err", ld_addr_q.size() + st_addr_q.size() + err_cnt, 0);

        // Reset during a load, then a fresh command.
        clear_logs();
        I_Rd_Ready = 1'b0;
        send_cmd(0, 2'd2, 0, 10'h040, 10'd8, 10'd4, t);
        for (int n = 0; n < 20 && ld_addr_q.size() < 2; n++) step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0; inject = 1'b1;
        @(negedge clock);
        check("mid_rst_flags", {O_Cmd_Ready, O_Busy, O_Ld_Req, O_St_Req, O_Rd_Valid, O_Wr_Ready, O_Done, O_Err}, 8'b1000_0000);
        step(1);
        inject = 1'b0;
        I_Rd_Ready = 1'b1;
        clear_logs();
        step(3);
        check("mid_rst_no_rd", rd_valid_cnt, 0);
        send_cmd(0, 2'd2, 0, 10'h010, 10'd2, 10'd4, t);
        wait_done("fresh", 30);
        check("fresh_nrd", rd_q.size(), 2);
        check("fresh_d0", rd_q[0], 32'h11223344);
        check("fresh_d1", rd_q[1], 32'hA5A50001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cram_stream_master.md
# cram_stream_master

Initiator-side companion to the configurable on-chip RAM. The block accepts one block-transfer command (base, length, stride, access width, direction) and sequences it into per-element load or store requests on the RAM's Ld/St port, using byte/half/word modes. Load responses come back through a 2-entry buffer onto a valid/ready output stream, and store data is taken from a valid/ready input stream. It sits between a compute element's streaming datapath and a local RAM instance.

## Interface
Parameters:
- WIDTH_DATA, 32, element/bus data width.
- WIDTH_ADDR, 10, byte address width; arithmetic wraps modulo 2^WIDTH_ADDR.
- WIDTH_LENGTH, 10, element-count width.
- BUF_DEPTH, 2, load-return buffer depth (fixed at 2 for this release).

Ports (reset reset, synchronous, active-high; clock clock):
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- I_Cmd_Valid  in  1  command offered
- O_Cmd_Ready  out  1  high only in IDLE
- I_Cmd_Store  in  1  1=store, 0=load
- I_Cmd_Mode  in  2  0 byte, 1 half, 2 word, 3 reserved
- I_Cmd_Signed  in  1  sign-extend byte/half loads
- I_Cmd_Base  in  WIDTH_ADDR  first byte address
- I_Cmd_Length  in  WIDTH_LENGTH  element count
- I_Cmd_Stride  in  WIDTH_ADDR  byte increment per element
- O_Ld_Req / O_St_Req  out  1  memory request strobes
- O_Ld_Mode / O_St_Mode  out  2  access width (equals latched mode)
- O_Ld_Address / O_St_Address  out  WIDTH_ADDR  byte address
- O_St_Data  out  WIDTH_DATA  store data (pass-through of I_Wr_Data)
- I_Ld_Valid  in  1  load response, exactly 1 cycle after O_Ld_Req
- I_Ld_Data  in  WIDTH_DATA  right-justified, zero-filled response
- I_Wr_Valid / O_Wr_Ready  in/out  1  store stream handshake
- I_Wr_Data  in  WIDTH_DATA  store element
- O_Rd_Valid / I_Rd_Ready  out/in  1  load stream handshake
- O_Rd_Data  out  WIDTH_DATA  load element
- O_Busy  out  1  state != IDLE
- O_Done  out  1  one-cycle pulse at transfer end
- O_Err  out  1  one-cycle pulse on rejected command

All outputs reset to 0 except O_Cmd_Ready, which is 1.

## Operation
- FSM: IDLE, LOAD, STORE, DRAIN, DONE.
- IDLE: on I_Cmd_Valid, latch the command.
  - Mode 3, or misalignment (half: base[0]|stride[0]; word: base[1:0]|stride[1:0] nonzero): pulse O_Err next cycle, stay IDLE, issue no requests.
  - Length 0: go to DONE.
  - Otherwise go to LOAD or STORE.
- Address register starts at base and adds stride after each issued request, wrapping mod 2^WIDTH_ADDR. A down-counter holds the remaining elements.
- STORE:
  - O_Wr_Ready = 1.
  - O_St_Req = I_Wr_Valid; each handshake issues one store.
  - After the last element, go to DONE.
  - Byte and half elements are taken from the low bits of I_Wr_Data; the RAM handles lane placement.
- LOAD:
  - Issue O_Ld_Req when buffer_count + inflight − pop_this_cycle < 2. inflight is 1 for the cycle after a request.
  - I_Ld_Valid pushes into the buffer.
  - Byte loads sign- or zero-extend bit 7 into O_Rd_Data; half loads sign- or zero-extend bit 15, both per the latched I_Cmd_Signed. Word loads pass through.
  - After the last request, go to DRAIN.
- DRAIN: wait until inflight = 0 and the buffer is empty, then go to DONE.
- DONE: O_Done = 1 for one cycle, then IDLE.
- I_Ld_Valid outside an expected slot is ignored.

## Timing
- Command handshake at cycle T. First request at T+1. Load data on I_Ld_Valid at T+2; O_Rd_Valid at T+3.
- Throughput is one element per cycle in both directions while the stream partner is ready.
- Buffer full with I_Rd_Ready low: no new O_Ld_Req. The buffer never overflows, and no response is lost.
- Simultaneous buffer push and pop: count is unchanged, and data order is preserved.
- Store: O_Done at the cycle after the last handshake +1. Load: O_Done at the cycle after the last O_Rd handshake +1.
- Reset mid-transfer: FSM returns to IDLE, counters and buffer clear, and a response arriving the cycle after reset is discarded.

## Structure
- Add to pkg_en:
  - access-mode constants MODE_BYTE=0, MODE_SHORT=1, MODE_INT=2, MODE_RSVD=3;
  - cram_master_state_t enum.
- One sub-module, stream_skid_fifo: a 2-entry synchronous FIFO with count output and simultaneous push/pop. The FSM, address/count datapath and extension logic stay in the top module.

## Test plan
- Word load: base 0x010, stride 4, length 4, I_Rd_Ready=1 → addresses 0x010, 0x014, 0x018, 0x01C on consecutive cycles; 4 words returned in order; O_Done at T+7.
- Signed byte load: memory byte 0x80 at 0x005, Signed=1 → O_Rd_Data=0xFFFFFF80. With Signed=0 → 0x00000080.
- Half store: base 0x3FE, stride 2, length 2 → O_St_Address 0x3FE then 0x000 (wrap); O_St_Mode=1.
- Backpressure: word load of length 6 with I_Rd_Ready low for 5 cycles mid-stream → at most 2 buffered, no requests while full, all 6 words delivered in order.
- Rejects: mode 3, or word base 0x002 → O_Err pulse, no Ld/St requests, O_Cmd_Ready stays 1. Length 0 → O_Done pulse only.
- Reset during load at element 2 of 8 → outputs return to reset values; a subsequent fresh command completes correctly.
